// File: rtl/vcore_pkg.sv
// vcore_pkg: shared definitions for the vector-processor cache NOC mux.
//   - client source IDs carried in the request/response transaction ID
//   - request/response payload structs of the CPU cache interface
//   - default per-port response configuration and source-ID table
package vcore_pkg;

  localparam int VP_SRC_W = 4;

  localparam logic [VP_SRC_W-1:0] VP_ORV64_SRC_ID  = 4'h1;
  localparam logic [VP_SRC_W-1:0] VP_VLOAD_SRC_ID  = 4'h2;
  localparam logic [VP_SRC_W-1:0] VP_VSTORE_SRC_ID = 4'h3;

  typedef enum logic [1:0] {
    REQ_LOAD     = 2'd0,
    REQ_STORE    = 2'd1,
    REQ_PREFETCH = 2'd2
  } cpu_cache_req_type_e;

  typedef struct packed {
    logic [VP_SRC_W-1:0] src;
    logic [3:0]          tid;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    cpu_cache_req_type_e req_type;
    logic [31:0]         addr;
    logic [31:0]         data;
    cpu_cache_if_tid_t   req_tid;
  } cpu_cache_if_req_t;

  typedef struct packed {
    cpu_cache_if_tid_t resp_tid;
    logic [31:0]       data;
  } cpu_cache_if_resp_t;

  // Up to 8 ports; only the low N_PORT entries are used.
  // Port 0 = scalar core, port 1 = VSTORE (posted), port 2 = VLOAD.
  localparam logic [7:0]  VP_DEFAULT_HAS_RESP = 8'b0000_0101;
  localparam logic [31:0] VP_DEFAULT_SRC_ID   =
    {20'h0, VP_VLOAD_SRC_ID, VP_VSTORE_SRC_ID, VP_ORV64_SRC_ID};

  // Extract the source ID of port idx from a packed 8 x 4-bit table.
  function automatic logic [VP_SRC_W-1:0] vp_src_of(input logic [31:0] tbl, input int idx);
    return tbl[idx*VP_SRC_W +: VP_SRC_W];
  endfunction

endpackage

// File: rtl/ours_vld_rdy_buf.sv
// ours_vld_rdy_buf: valid/ready FIFO buffer.
//   clk, rstn        : clock, asynchronous active-low reset
//   i_vld/i_data/o_rdy : write side; o_rdy = not full
//   o_vld/o_data/i_rdy : read side; o_data is the head, stable until popped
module ours_vld_rdy_buf #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_vld,
  input  T     i_data,
  output logic o_rdy,
  output logic o_vld,
  output T     o_data,
  input  logic i_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign o_rdy  = (r_cnt != CW'(DEPTH));
  assign o_vld  = (r_cnt != '0);
  assign o_data = r_mem[r_rd_ptr];
  assign w_push = i_vld && o_rdy;
  assign w_pop  = o_vld && i_rdy;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/vp_cache_noc_rr_arb.sv
// vp_cache_noc_rr_arb: N-input round-robin arbiter.
//   clk, rstn   : clock, asynchronous active-low reset
//   i_eligible  : per-input request mask (already qualified by throttling)
//   i_enable    : grant permitted this cycle (downstream slot free)
//   o_grant     : one-hot grant; pointer moves past the winner on a grant
module vp_cache_noc_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] i_eligible,
  input  logic         i_enable,
  output logic [N-1:0] o_grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [PW:0]   w_idx;
  logic [PW-1:0] w_idx_lo;
  logic          w_any;

  // Scan from the pointer, wrapping modulo N; the first eligible input wins.
  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_any      = 1'b0;
    w_idx      = '0;
    w_idx_lo   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      w_idx_lo = w_idx[PW-1:0];
      if (i_enable && !w_any && i_eligible[w_idx_lo]) begin
        o_grant[w_idx_lo] = 1'b1;
        w_any             = 1'b1;
        w_ptr_next        = (w_idx_lo == PW'(N-1)) ? '0 : w_idx_lo + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_ptr <= '0;
    else if (w_any) r_ptr <= w_ptr_next;
  end

endmodule

// File: rtl/vp_cache_noc_mux.sv
// vp_cache_noc_mux: N-port request arbiter / response router to the NOC cache IF.
//   clk, rstn                : clock, asynchronous active-low reset
//   cpu_if_req_valid/req/ready  : per-port request channels (ready = grant)
//   cpu_if_resp_valid/resp/ready: per-port response valid/ready, broadcast payload
//   cache_if_req_*           : registered NOC request channel
//   cache_if_resp_*          : NOC response channel into the response FIFO
//   unrouted_resp            : pulse when the FIFO head matches no response port
module vp_cache_noc_mux
  import vcore_pkg::*;
#(
  parameter int          N_PORT     = 3,
  parameter int          MAX_OUTS   = 4,
  parameter int          RESP_DEPTH = 2,
  parameter logic [7:0]  HAS_RESP   = VP_DEFAULT_HAS_RESP,
  parameter logic [31:0] SRC_ID     = VP_DEFAULT_SRC_ID
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_PORT-1:0]                  cpu_if_req_valid,
  input  cpu_cache_if_req_t [N_PORT-1:0]     cpu_if_req,
  output logic [N_PORT-1:0]                  cpu_if_req_ready,
  output logic [N_PORT-1:0]                  cpu_if_resp_valid,
  output cpu_cache_if_resp_t                 cpu_if_resp,
  input  logic [N_PORT-1:0]                  cpu_if_resp_ready,
  output logic                               cache_if_req_valid,
  output cpu_cache_if_req_t                  cache_if_req,
  input  logic                               cache_if_req_ready,
  input  logic                               cache_if_resp_valid,
  input  cpu_cache_if_resp_t                 cache_if_resp,
  output logic                               cache_if_resp_ready,
  output logic                               unrouted_resp
);
  localparam int CNT_W = 4;

  logic [N_PORT-1:0]  w_eligible;
  logic [N_PORT-1:0]  w_grant;
  logic               w_can_load;
  cpu_cache_if_req_t  w_sel_req;
  logic               r_req_valid;
  cpu_cache_if_req_t  r_req;

  logic               w_head_vld;
  cpu_cache_if_resp_t w_head;
  logic               w_head_pop;
  logic [N_PORT-1:0]  w_match;
  logic [N_PORT-1:0]  w_route;
  logic               w_found;

  // ---------------- request path ----------------
  // Grant only if the single output slot is empty or drains this cycle.
  assign w_can_load = !r_req_valid || cache_if_req_ready;

  vp_cache_noc_rr_arb #(.N(N_PORT)) u_arb (
    .clk        (clk),
    .rstn       (rstn),
    .i_eligible (w_eligible),
    .i_enable   (w_can_load),
    .o_grant    (w_grant)
  );

  assign cpu_if_req_ready = w_grant;

  always_comb begin
    w_sel_req = '0;
    for (int i = 0; i < N_PORT; i++) begin
      if (w_grant[i]) w_sel_req = cpu_if_req[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   r_req_valid <= 1'b0;
    else if (|w_grant)           r_req_valid <= 1'b1;
    else if (cache_if_req_ready) r_req_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (|w_grant) r_req <= w_sel_req;
  end

  assign cache_if_req_valid = r_req_valid;
  assign cache_if_req       = r_req;

  // ---------------- per-port throttling ----------------
  for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
    logic [CNT_W-1:0] r_outs_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc = w_grant[gi] && HAS_RESP[gi];
    assign w_dec = cpu_if_resp_valid[gi] && cpu_if_resp_ready[gi];
    // Registered count only: a decrement this cycle unblocks next cycle.
    assign w_eligible[gi] = cpu_if_req_valid[gi] &&
                            (!HAS_RESP[gi] || (r_outs_cnt < CNT_W'(MAX_OUTS)));
    assign w_match[gi] = HAS_RESP[gi] && (w_head.resp_tid.src == vp_src_of(SRC_ID, gi));

    // Decrement saturates at 0 so responses outstanding across a reset are harmless.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                   r_outs_cnt <= '0;
      else if (w_inc && !w_dec)                    r_outs_cnt <= r_outs_cnt + CNT_W'(1);
      else if (w_dec && !w_inc && r_outs_cnt != 0) r_outs_cnt <= r_outs_cnt - CNT_W'(1);
    end
  end

  // ---------------- response path ----------------
  ours_vld_rdy_buf #(.T(cpu_cache_if_resp_t), .DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .i_vld  (cache_if_resp_valid),
    .i_data (cache_if_resp),
    .o_rdy  (cache_if_resp_ready),
    .o_vld  (w_head_vld),
    .o_data (w_head),
    .i_rdy  (w_head_pop)
  );

  // Lowest-index matching response port owns the head.
  always_comb begin
    w_route = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_PORT; i++) begin
      if (w_match[i] && !w_found) begin
        w_route[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign cpu_if_resp_valid = {N_PORT{w_head_vld}} & w_route;
  assign cpu_if_resp       = w_head;
  assign unrouted_resp     = w_head_vld && !w_found;
  // An orphan head is discarded immediately so it cannot block the FIFO.
  assign w_head_pop        = w_head_vld && (!w_found || |(w_route & cpu_if_resp_ready));

endmodule
